// File: rtl/bpt_pkg.sv
// Shared types and counter helpers for branch_predictor_table.
// Optional gshare mode in the top is selected by the BPT_GHR_EN macro.
package bpt_pkg;

  // Widest PC the shared entry struct can hold. The top supports XLEN up to this value.
  localparam int BPT_XLEN    = 32;
  // Widest possible tag. The smallest table (ENTRIES=2) leaves XLEN-3 tag bits.
  localparam int BPT_TAG_W   = BPT_XLEN - 3;
  // Widest supported saturating counter.
  localparam int BPT_CTR_MAX = 4;

  typedef logic [BPT_CTR_MAX-1:0] ctr_t;

  // A narrower tag or target is zero-extended into this struct.
  typedef struct packed {
    logic                 valid;
    logic [BPT_TAG_W-1:0] tag;
    logic [BPT_XLEN-1:0]  target;
  } bpt_entry_t;

  // Largest value a w-bit counter can hold.
  function automatic ctr_t ctr_max(input int unsigned w);
    return ctr_t'((5'd1 << w) - 5'd1);
  endfunction

  // Increment that sticks at the top of a w-bit range.
  function automatic ctr_t sat_inc(input ctr_t c, input int unsigned w);
    return (c == ctr_max(w)) ? c : c + ctr_t'(1);
  endfunction

  // Decrement that sticks at zero.
  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == '0) ? c : c - ctr_t'(1);
  endfunction

  // Weakly-taken starting value for a newly allocated entry. Only the MSB is set.
  function automatic ctr_t wt_init(input int unsigned w);
    return ctr_t'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// CTR_W-bit saturating counter with load, increment and decrement controls.
// Load has the highest priority, then increment, then decrement.
module sat_counter
  import bpt_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [CTR_W-1:0] load_val_i,
  output logic [CTR_W-1:0] cnt_o
);

  logic [CTR_W-1:0] cnt_q, cnt_d;
  ctr_t             cnt_ext;

  assign cnt_ext = ctr_t'(cnt_q);
  assign cnt_o   = cnt_q;

  // Next count: load wins; the helpers clamp at either end.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = load_val_i;
    else if (inc_i) cnt_d = CTR_W'(sat_inc(cnt_ext, CTR_W));
    else if (dec_i) cnt_d = CTR_W'(sat_dec(cnt_ext));
  end

  // Count register. It clears asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/branch_predictor_table.sv
// Direct-mapped branch predictor: per-entry saturating counters plus a tagged BTB.
// Lookup is combinational from IF_pc. Training happens on the clock edge from EX.
// Define BPT_GHR_EN for gshare mode: the counters are indexed by idx^GHR, and the
// BTB keeps plain-PC indexing.
module branch_predictor_table
  import bpt_pkg::*;
#(
  parameter  int ENTRIES = 16,
  parameter  int CTR_W   = 2,
  parameter  int XLEN    = 32,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [XLEN-1:0]  IF_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
`ifdef BPT_GHR_EN
  output logic [IDX_W-1:0] pred_ghr,
  input  logic [IDX_W-1:0] upd_ghr,
`endif
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target
);

  localparam int   TAG_W = XLEN - IDX_W - 2;
  localparam ctr_t WT    = wt_init(CTR_W);

  bpt_entry_t       btb_q [ENTRIES];
  bpt_entry_t       btb_d [ENTRIES];
  logic [CTR_W-1:0] ctr   [ENTRIES];

  logic [IDX_W-1:0] if_idx, if_cidx, upd_idx, upd_cidx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             if_hit, upd_hit;
  logic             unused_upd_lsb;

  assign if_idx  = IF_pc[IDX_W+1:2];
  assign if_tag  = IF_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
  // The byte offset of the resolved PC has no role in indexing or tagging.
  assign unused_upd_lsb = ^upd_pc[1:0];

`ifdef BPT_GHR_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign if_cidx  = if_idx ^ ghr_q;
  assign upd_cidx = upd_idx ^ upd_ghr;
  assign pred_ghr = ghr_q;

  // Rebuilding the history from the carried snapshot shifts in the new outcome.
  // It also repairs the history after a mispredict.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = (upd_ghr << 1) | IDX_W'(upd_taken);
  end

  // Global history register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end
`else
  assign if_cidx  = if_idx;
  assign upd_cidx = upd_idx;
`endif

  assign if_hit  = btb_q[if_idx].valid  && (btb_q[if_idx].tag  == BPT_TAG_W'(if_tag));
  assign upd_hit = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == BPT_TAG_W'(upd_tag));

  // Prediction reads registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    pred_hit    = if_hit;
    pred_taken  = if_hit && ctr[if_cidx][CTR_W-1];
    pred_target = pred_taken ? XLEN'(btb_q[if_idx].target) : IF_pc + XLEN'(4);
  end

  // A taken resolution always writes the BTB slot. On a hit this rewrites the same tag
  // and refreshes the target. On a miss it allocates the slot. Not-taken leaves the BTB alone.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) btb_d[i] = btb_q[i];
    if (upd_valid && upd_taken) begin
      btb_d[upd_idx].valid  = 1'b1;
      btb_d[upd_idx].tag    = BPT_TAG_W'(upd_tag);
      btb_d[upd_idx].target = BPT_XLEN'(upd_target);
    end
  end

  // BTB storage. It clears asynchronously, so a reset during an update discards the update.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= btb_d[i];
    end
  end

  // One counter per entry. A hit trains the counter up or down. A taken miss seeds it weakly taken.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic sel;
    assign sel = upd_valid && (upd_cidx == IDX_W'(g));

    sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk_i      (CLK),
      .rst_ni     (RST),
      .inc_i      (sel &&  upd_hit &&  upd_taken),
      .dec_i      (sel &&  upd_hit && !upd_taken),
      .load_i     (sel && !upd_hit &&  upd_taken),
      .load_val_i (CTR_W'(WT)),
      .cnt_o      (ctr[g])
    );
  end

endmodule
